// File: rtl/bsg_mem_1rw_sync_mask_write_byte_client.sv
// Initiator-side adapter for a 1rw synchronous byte-masked memory.
// Turns ready/valid requests into memory pin activity, optionally zero-fills
// the array after reset, and queues read data in a credit-managed buffer.
//
// state  | meaning
// eInit  | zero-filling the array, one word per cycle, requests blocked
// eReady | fill done, requests accepted while read credits remain

module bsg_mem_1rw_sync_mask_write_byte_client #(
    parameter  int data_width_p        = 32,
    parameter  int els_p               = 16,
    parameter  int init_p              = 1,
    parameter  int buf_els_p           = 3,
    localparam int addr_width_lp       = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int write_mask_width_lp = data_width_p >> 3
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,

    input  logic                           v_i,
    input  logic                           w_i,
    input  logic [addr_width_lp-1:0]       addr_i,
    input  logic [data_width_p-1:0]        data_i,
    input  logic [write_mask_width_lp-1:0] write_mask_i,
    output logic                           ready_o,

    output logic                           v_o,
    output logic [data_width_p-1:0]        data_o,
    input  logic                           yumi_i,

    output logic                           init_done_o,

    output logic                           mem_v_o,
    output logic                           mem_w_o,
    output logic [addr_width_lp-1:0]       mem_addr_o,
    output logic [data_width_p-1:0]        mem_data_o,
    output logic [write_mask_width_lp-1:0] mem_w_mask_o,
    input  logic [data_width_p-1:0]        mem_data_i
);

    localparam int ptr_w_lp = (buf_els_p > 1) ? $clog2(buf_els_p) : 1;
    // occupancy may momentarily count buf_els_p plus the in-flight read
    localparam int cnt_w_lp = $clog2(buf_els_p + 2);

    localparam logic [addr_width_lp-1:0] last_addr_lp = addr_width_lp'(els_p - 1);
    localparam logic [ptr_w_lp-1:0]      last_ptr_lp  = ptr_w_lp'(buf_els_p - 1);
    localparam logic [cnt_w_lp-1:0]      credits_lp   = cnt_w_lp'(buf_els_p);

    typedef enum logic {eInit = 1'b0, eReady = 1'b1} state_e;

    state_e                    state_q, state_d;
    logic [addr_width_lp-1:0]  fill_cnt_q, fill_cnt_d;
    logic                      pend_q, pend_d;
    logic [ptr_w_lp-1:0]       head_q, head_d, tail_q, tail_d;
    logic [cnt_w_lp-1:0]       count_q, count_d;
    logic [data_width_p-1:0]   buf_q [buf_els_p];

    logic [cnt_w_lp-1:0]       occ;
    logic                      credit_ok;
    logic                      issue;
    logic                      push;
    logic                      pop;

    // Credits depend only on registered state so ready_o never sees v_i/yumi_i.
    assign occ       = cnt_w_lp'(pend_q) + count_q;
    assign credit_ok = occ < credits_lp;
    assign issue     = reset_n_i & (state_q == eReady) & credit_ok & v_i;
    assign push      = pend_q;
    assign v_o       = (count_q != '0);
    assign pop       = yumi_i & v_o;
    assign data_o    = buf_q[head_q];

    // State, fill counter, pending-read flag and buffer pointers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= (init_p != 0) ? eInit : eReady;
            fill_cnt_q <= '0;
            pend_q     <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            pend_q     <= pend_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Next state: walk the fill counter to the last word, then go ready.
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        pend_d     = issue & ~w_i;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        case (state_q)
            eInit: begin
                fill_cnt_d = fill_cnt_q + 1'b1;
                if (fill_cnt_q == last_addr_lp) state_d = eReady;
            end
            eReady: ;
            default: state_d = eReady;
        endcase
        if (push) tail_d = (tail_q == last_ptr_lp) ? '0 : tail_q + 1'b1;
        if (pop)  head_d = (head_q == last_ptr_lp) ? '0 : head_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Outputs: fill writes in eInit, pass-through of the request in eReady.
    always_comb begin
        ready_o      = 1'b0;
        init_done_o  = 1'b0;
        mem_v_o      = 1'b0;
        mem_w_o      = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        mem_w_mask_o = '0;
        case (state_q)
            eInit: begin
                mem_v_o      = reset_n_i;
                mem_w_o      = 1'b1;
                mem_addr_o   = fill_cnt_q;
                mem_w_mask_o = '1;
            end
            eReady: begin
                ready_o      = reset_n_i & credit_ok;
                init_done_o  = reset_n_i;
                mem_v_o      = issue;
                mem_w_o      = w_i;
                mem_addr_o   = addr_i;
                mem_data_o   = data_i;
                mem_w_mask_o = write_mask_i;
            end
            default: ;
        endcase
    end

    // Response storage; contents need no reset since count_q gates v_o.
    always_ff @(posedge clk_i) begin
        if (push) buf_q[tail_q] <= mem_data_i;
    end

    // Simulation checks on parameters and consumer protocol.
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (data_width_p % 8 == 0) else $error("data_width_p must be a multiple of 8");
            assert (buf_els_p >= 1)        else $error("buf_els_p must be at least 1");
            assert (els_p >= 1)            else $error("els_p must be at least 1");
            assert (!(yumi_i && !v_o))     else $error("yumi_i asserted while v_o is low");
            assert (!(push && !pop && count_q == credits_lp)) else $error("response buffer overflow");
        end
    end

endmodule

// File: tb/tb_bsg_mem_1rw_sync_mask_write_byte_client.sv
module tb_bsg_mem_1rw_sync_mask_write_byte_client;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        v_i, w_i, yumi_i;
    logic [3:0]  addr_i;
    logic [31:0] data_i;
    logic [3:0]  write_mask_i;
    logic        ready_o, v_o, init_done_o;
    logic [31:0] data_o;
    logic        mem_v_o, mem_w_o;
    logic [3:0]  mem_addr_o;
    logic [31:0] mem_data_o;
    logic [3:0]  mem_w_mask_o;
    logic [31:0] mem_data_i;

    int checks = 0;
    int errors = 0;

    bsg_mem_1rw_sync_mask_write_byte_client #(
        .data_width_p(32), .els_p(16), .init_p(1), .buf_els_p(3)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .v_i(v_i), .w_i(w_i), .addr_i(addr_i), .data_i(data_i),
        .write_mask_i(write_mask_i), .ready_o(ready_o),
        .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i),
        .init_done_o(init_done_o),
        .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_w_mask_o(mem_w_mask_o),
        .mem_data_i(mem_data_i)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural 1rw synchronous byte-masked memory, 1-cycle read latency.
    logic [31:0] mem_model [16];
    logic [31:0] rdata_q = 32'h0;
    assign mem_data_i = rdata_q;
    always @(posedge clk_i) begin
        if (mem_v_o) begin
            if (mem_w_o) begin
                for (int b = 0; b < 4; b++)
                    if (mem_w_mask_o[b]) mem_model[mem_addr_o][b*8 +: 8] <= mem_data_o[b*8 +: 8];
            end else begin
                rdata_q <= mem_model[mem_addr_o];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int a);
        return 32'hC0DE_0000 + 32'(a) * 32'h0000_0101;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int sent, got, first_cyc, last_cyc, acc;
        reset_n_i = 1'b0; v_i = 1'b0; w_i = 1'b0; yumi_i = 1'b0;
        addr_i = '0; data_i = '0; write_mask_i = '0;
        for (int i = 0; i < 16; i++) mem_model[i] = 32'hFFFF_FFFF;

        // ---- reset state ----
        @(negedge clk_i); @(negedge clk_i);
        check("rst_ready", ready_o, 0);
        check("rst_v_o", v_o, 0);
        check("rst_mem_v", mem_v_o, 0);
        check("rst_done", init_done_o, 0);

        // ---- 1: zero fill over 16 cycles ----
        reset_n_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            check("fill_v", {mem_v_o, mem_w_o}, 2'b11);
            check("fill_addr", mem_addr_o, i);
            check("fill_data", mem_data_o, 0);
            check("fill_mask", mem_w_mask_o, 4'hF);
            check("fill_ready", ready_o, 0);
            @(negedge clk_i);
        end
        check("fill_done", init_done_o, 1);
        check("fill_ready_up", ready_o, 1);
        check("fill_mem5", mem_model[5], 0);

        // ---- 2: masked write then read ----
        v_i = 1; w_i = 1; addr_i = 4'd5; data_i = 32'hDEADBEEF; write_mask_i = 4'b0101;
        #1;
        check("wr_mem_v", {mem_v_o, mem_w_o}, 2'b11);
        check("wr_addr", mem_addr_o, 5);
        check("wr_data", mem_data_o, 32'hDEADBEEF);
        check("wr_mask", mem_w_mask_o, 4'b0101);
        @(negedge clk_i);
        w_i = 0;
        #1;
        check("rd_mem_v", {mem_v_o, mem_w_o}, 2'b10);
        @(negedge clk_i);
        v_i = 0;
        check("rd_lat1_v", v_o, 0);
        @(negedge clk_i);
        check("rd_lat2_v", v_o, 1);
        check("rd_data", data_o, 32'h00AD00EF);
        yumi_i = 1;
        @(negedge clk_i);
        yumi_i = 0;
        check("rd_popped", v_o, 0);

        // preload distinct words
        w_i = 1; write_mask_i = 4'hF;
        for (int a = 0; a < 16; a++) begin
            v_i = 1; addr_i = 4'(a); data_i = pat(a);
            @(negedge clk_i);
        end
        v_i = 0; w_i = 0;
        @(negedge clk_i);

        // ---- 3: 20 back-to-back reads with yumi = v_o ----
        sent = 0; got = 0; first_cyc = -1; last_cyc = -1;
        for (int cyc = 0; cyc < 40 && got < 20; cyc++) begin
            if (cyc != 0) @(negedge clk_i);
            yumi_i = v_o;
            if (v_o) begin
                check("stream_data", data_o, pat(got % 16));
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                got++;
            end
            if (sent < 20) begin
                check("stream_ready", ready_o, 1);
                v_i = 1; w_i = 0; addr_i = 4'(sent % 16);
                sent++;
            end else begin
                v_i = 0;
            end
        end
        check("stream_count", got, 20);
        check("stream_rate", last_cyc - first_cyc, 19);
        @(negedge clk_i);
        yumi_i = 0; v_i = 0;
        check("stream_empty", v_o, 0);

        // ---- 4: credit exhaustion with yumi held low ----
        acc = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk_i);
            if (ready_o) begin
                v_i = 1; w_i = 0; addr_i = 4'(acc); acc++;
            end else begin
                v_i = 0;
            end
        end
        v_i = 0;
        check("credit_accepted", acc, 3);
        check("credit_ready", ready_o, 0);
        check("credit_v_o", v_o, 1);
        check("credit_head", data_o, pat(0));
        yumi_i = 1;
        @(negedge clk_i);
        yumi_i = 0;
        check("credit_ready_back", ready_o, 1);
        check("credit_head1", data_o, pat(1));
        yumi_i = 1;
        @(negedge clk_i);
        check("credit_head2", data_o, pat(2));
        @(negedge clk_i);
        yumi_i = 0;
        check("credit_drained", v_o, 0);

        // ---- 5: write/read interleave on one address ----
        v_i = 1; w_i = 1; addr_i = 4'd3; data_i = 32'h1234_5678; write_mask_i = 4'hF;
        @(negedge clk_i);
        w_i = 0;
        @(negedge clk_i);
        w_i = 1; data_i = 32'h9ABC_DEF0;
        @(negedge clk_i);
        w_i = 0;
        @(negedge clk_i);
        v_i = 0;
        @(negedge clk_i);
        @(negedge clk_i);
        check("order_v", v_o, 1);
        check("order_A", data_o, 32'h1234_5678);
        yumi_i = 1;
        @(negedge clk_i);
        check("order_B", data_o, 32'h9ABC_DEF0);
        @(negedge clk_i);
        yumi_i = 0;
        check("order_empty", v_o, 0);

        // ---- 6: reset with reads in flight ----
        v_i = 1; w_i = 0; addr_i = 4'd7;
        @(negedge clk_i);
        addr_i = 4'd8;
        @(negedge clk_i);
        v_i = 0;
        #1;
        reset_n_i = 1'b0;
        #1;
        check("midrst_v_o", v_o, 0);
        check("midrst_ready", ready_o, 0);
        check("midrst_mem_v", mem_v_o, 0);
        check("midrst_done", init_done_o, 0);
        @(negedge clk_i); @(negedge clk_i);
        reset_n_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            check("refill_addr", mem_addr_o, i);
            check("refill_v", mem_v_o, 1);
            check("refill_nostale", v_o, 0);
            @(negedge clk_i);
        end
        check("refill_ready", ready_o, 1);
        for (int i = 0; i < 4; i++) begin
            check("after_nostale", v_o, 0);
            @(negedge clk_i);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
